regfile_rd2w1: RTL

- 32 x 32-bit register file for the processor datapath.
- Built as 32 word registers: one synchronous write port, two independent combinational read ports.
- Provides the read side of the word-register storage: decode, select and drive stored words to the decode/execute stage.
- Register 0 is hardwired to zero.

---
 rtl/regfile_rd2w1.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_rd2w1.sv
// regfile_rd2w1: NREGS x WIDTH register file, one synchronous write port and
// two independent combinational read ports. Register 0 always reads zero.
//
// Ports:
//   clock            - system clock, writes on rising edge
//   ctrl_reset       - asynchronous active-high reset, clears all registers
//   ctrl_writeEnable - write strobe, sampled at rising edge of clock
//   ctrl_writeReg    - destination register index
//   data_writeReg    - write data
//   ctrl_readRegA    - read port A index
//   ctrl_readRegB    - read port B index
//   data_readRegA    - read port A data (combinational)
//   data_readRegB    - read port B data (combinational)
module regfile_rd2w1 #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_writeEnable,
  input  logic [AW-1:0]    ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [AW-1:0]    ctrl_readRegA,
  input  logic [AW-1:0]    ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [NREGS-1:0] we_onehot;
  logic [NREGS-1:0] sel_a;
  logic [NREGS-1:0] sel_b;
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             byp_a;
  logic             byp_b;

  // One-hot decodes. Bit 0 is tied low everywhere so register 0 is never
  // written and never selected; its storage stays at the reset value.
  assign we_onehot[0] = 1'b0;
  assign sel_a[0]     = 1'b0;
  assign sel_b[0]     = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_dec
    assign we_onehot[i] = ctrl_writeEnable && (ctrl_writeReg == AW'(i));
    assign sel_a[i]     = (ctrl_readRegA == AW'(i));
    assign sel_b[i]     = (ctrl_readRegB == AW'(i));
  end

  // Reset on its own edge so contents clear without a clock; reset also wins
  // over a coincident write edge.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (we_onehot[i]) begin
          mem_q[i] <= data_writeReg;
        end
      end
    end
  end

  // AND-OR select: with a one-hot select this is a mux that can never float,
  // and an all-zero select (index 0) yields zero.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (sel_a[i]) mux_a = mux_a | mem_q[i];
      if (sel_b[i]) mux_b = mux_b | mem_q[i];
    end
  end

  // Write-through forwarding; the write decode already excludes index 0.
  assign byp_a = BYPASS && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) &&
                 (ctrl_readRegA != '0);
  assign byp_b = BYPASS && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) &&
                 (ctrl_readRegB != '0);

  assign data_readRegA = byp_a ? data_writeReg : mux_a;
  assign data_readRegB = byp_b ? data_writeReg : mux_b;

endmodule
